// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data RAM.
// Define DMEM_ARB_FIXED_PRIO_EN to make port A win every tie.
module dmem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_read_address,
  output logic [ADDR_W-1:0] ram_write_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } state_e;

  typedef struct packed {
    logic              we;
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } xact_t;

  state_e state_q, state_d;
  xact_t  xact_q, xact_d;

  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic a_ack_q, a_ack_d;
  logic b_ack_q, b_ack_d;
  logic busy_q, busy_d;

  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic gnt_v;
  logic gnt_port;
  logic tie_port;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign tie_port = 1'b0;
`else
  // 0 = port A, 1 = port B; reset to B so A wins the first tie
  logic last_q, last_d;

  assign tie_port = ~last_q;
`endif

  assign gnt_v = a_req | b_req;

  always_comb begin
    gnt_port = 1'b0;
    unique case (1'b1)
      a_req && !b_req: gnt_port = 1'b0;
      b_req && !a_req: gnt_port = 1'b1;
      a_req && b_req:  gnt_port = tie_port;
      default:         gnt_port = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    xact_d    = xact_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifndef DMEM_ARB_FIXED_PRIO_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_v) begin
          state_d     = SETUP;
          xact_d.port = gnt_port;
          xact_d.we   = gnt_port ? b_we    : a_we;
          xact_d.addr = gnt_port ? b_addr  : a_addr;
          xact_d.wdata = gnt_port ? b_wdata : a_wdata;
`ifndef DMEM_ARB_FIXED_PRIO_EN
          last_d      = gnt_port;
`endif
        end
      end
      SETUP: begin
        state_d = STROBE;
        rd_en_d = ~xact_q.we;
        wr_en_d = xact_q.we;
      end
      STROBE: begin
        state_d = DONE;
        a_ack_d = ~xact_q.port;
        b_ack_d = xact_q.port;
        if (!xact_q.we) begin
          if (xact_q.port) b_rdata_d = ram_data_out;
          else             a_rdata_d = ram_data_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      xact_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      xact_q    <= xact_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

`ifndef DMEM_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  assign ram_read_enable   = rd_en_q;
  assign ram_write_enable  = wr_en_q;
  assign ram_read_address  = xact_q.addr;
  assign ram_write_address = xact_q.addr;
  assign ram_data_in       = xact_q.wdata;
  assign a_ack             = a_ack_q;
  assign b_ack             = b_ack_q;
  assign a_rdata           = a_rdata_q;
  assign b_rdata           = b_rdata_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model with a RAM
// that acts on the rising edge of each strobe.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, b_ack, busy;
  logic [DW-1:0] a_rdata, b_rdata;
  logic ram_re, ram_we;
  logic [AW-1:0] ram_ra, ram_wa;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .ram_read_enable(ram_re), .ram_write_enable(ram_we),
    .ram_read_address(ram_ra), .ram_write_address(ram_wa),
    .ram_data_in(ram_di), .ram_data_out(ram_do),
    .busy(busy)
  );

  function automatic logic [DW-1:0] preload(logic [AW-1:0] a);
    if (a == '0) return 32'h2222_2222;
    return 32'h9E37_79B9 * (32'(a) + 1);
  endfunction

  logic [DW-1:0] ram [1024];
  bit            ram_wv [1024];
  always @(posedge ram_we) begin
    ram[ram_wa] <= ram_di;
    ram_wv[ram_wa] <= 1'b1;
  end
  always @(posedge ram_re)
    ram_do <= ram_wv[ram_ra] ? ram[ram_ra] : preload(ram_ra);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  op_t a_q[$], b_q[$];
  int  acks[$];
  logic [DW-1:0] mdl_mem [1024];
  bit  pend [2];
  op_t cur [2];
  op_t gop;
  logic [DW-1:0] exp_rd [2];
  int  cnt = 0, gnt = 0, last = 1;
  bit  rnd_en = 0;
  int  checks = 0, errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tie();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    return 0;
`else
    return (last == 0) ? 1 : 0;
`endif
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.we   = 1'($urandom_range(1, 0));
    o.addr = ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(7, 0));
    o.data = $urandom;
    return o;
  endfunction

  task automatic drive();
    a_req   = pend[0];
    a_we    = pend[0] ? cur[0].we   : 1'($urandom);
    a_addr  = pend[0] ? cur[0].addr : AW'($urandom);
    a_wdata = pend[0] ? cur[0].data : $urandom;
    b_req   = pend[1];
    b_we    = pend[1] ? cur[1].we   : 1'($urandom);
    b_addr  = pend[1] ? cur[1].addr : AW'($urandom);
    b_wdata = pend[1] ? cur[1].data : $urandom;
  endtask

  // cnt = cycles since the grant edge (0 means arbiter idle)
  task automatic cycle();
    @(negedge clk);
    chk("busy", busy, cnt != 0);
    chk("a_ack", a_ack, cnt == 3 && gnt == 0);
    chk("b_ack", b_ack, cnt == 3 && gnt == 1);
    chk("rd_en", ram_re, cnt == 2 && !gop.we);
    chk("wr_en", ram_we, cnt == 2 && gop.we);
    chk("excl", ram_re & ram_we, 0);
    if (cnt != 0) begin
      chk("raddr", ram_ra, gop.addr);
      chk("waddr", ram_wa, gop.addr);
      chk("wdata", ram_di, gop.data);
    end
    chk("a_rdata", a_rdata, exp_rd[0]);
    chk("b_rdata", b_rdata, exp_rd[1]);
    if (a_ack) acks.push_back(0);
    if (b_ack) acks.push_back(1);
    if (cnt == 3) pend[gnt] = 0;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p]) begin
        if (p == 0 && a_q.size() != 0) begin
          cur[0] = a_q.pop_front(); pend[0] = 1;
        end else if (p == 1 && b_q.size() != 0) begin
          cur[1] = b_q.pop_front(); pend[1] = 1;
        end else if (rnd_en && $urandom_range(1, 0) == 1) begin
          cur[p] = rand_op(); pend[p] = 1;
        end
      end
    end
    drive();
    case (cnt)
      0: if (pend[0] || pend[1]) begin
        gnt  = (pend[0] && pend[1]) ? tie() : (pend[0] ? 0 : 1);
        last = gnt;
        gop  = cur[gnt];
        cnt  = 1;
      end
      1: begin
        if (gop.we) mdl_mem[gop.addr] = gop.data;
        cnt = 2;
      end
      2: begin
        if (!gop.we) exp_rd[gnt] = mdl_mem[gop.addr];
        cnt = 3;
      end
      default: cnt = 0;
    endcase
  endtask

  task automatic run_idle(int max);
    int i;
    for (i = 0; i < max; i++) begin
      cycle();
      if (!pend[0] && !pend[1] && cnt == 0 &&
          a_q.size() == 0 && b_q.size() == 0) break;
    end
    if (i == max) chk("idle_timeout", 1, 0);
  endtask

  op_t o;
  int  ord_exp [3];
  int  w;

  initial begin
    for (int i = 0; i < 1024; i++) mdl_mem[i] = preload(AW'(i));
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_a_ack", a_ack, 0);
    chk("rst_b_ack", b_ack, 0);
    chk("rst_strobes", {ram_re, ram_we}, 0);
    chk("rst_raddr", ram_ra, 0);
    chk("rst_waddr", ram_wa, 0);
    chk("rst_din", ram_di, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    rst_n = 1'b1;

    // B reads preloaded word 0; A stays silent
    b_q.push_back('{we: 1'b0, addr: 10'h000, data: 32'h0});
    run_idle(20);
    chk("b_rd_0", b_rdata, 32'h2222_2222);
    chk("a_rd_still_0", a_rdata, 0);

    // simultaneous back-to-back requests
`ifdef DMEM_ARB_FIXED_PRIO_EN
    ord_exp = '{0, 0, 0};
`else
    ord_exp = '{0, 1, 0};
`endif
    acks.delete();
    for (int i = 0; i < 3; i++) begin
      a_q.push_back(rand_op());
      b_q.push_back(rand_op());
    end
    run_idle(60);
    for (int i = 0; i < 3; i++)
      chk("grant_order", (acks.size() > i) ? acks[i] : 9, ord_exp[i]);

    a_q.push_back('{we: 1'b1, addr: 10'h005, data: 32'hDEAD_BEEF});
    a_q.push_back('{we: 1'b0, addr: 10'h005, data: 32'h0});
    run_idle(30);
    chk("a_rd_5", a_rdata, 32'hDEAD_BEEF);

    a_q.push_back('{we: 1'b1, addr: 10'h3FF, data: 32'h1234_5678});
    run_idle(30);
    b_q.push_back('{we: 1'b0, addr: 10'h3FF, data: 32'h0});
    run_idle(30);
    chk("b_rd_3ff", b_rdata, 32'h1234_5678);

    // reset while an A write is strobing
    a_q.push_back('{we: 1'b1, addr: 10'h0AA, data: 32'hCAFE_F00D});
    w = 0;
    while (!(cnt == 2 && gop.we) && w < 20) begin
      cycle();
      w++;
    end
    chk("reach_strobe", w < 20, 1);
    @(posedge clk);
    #2;
    chk("pre_rst_wr", ram_we, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {ram_re, ram_we}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ack", {a_ack, b_ack}, 0);
    chk("mid_rst_rdata", {a_rdata, b_rdata}, 0);
    cnt = 0;
    last = 1;
    pend[0] = 0;
    pend[1] = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    drive();
    @(negedge clk);
    chk("rst_no_ack", {a_ack, b_ack}, 0);
    rst_n = 1'b1;
    a_q.push_back('{we: 1'b0, addr: 10'h0AA, data: 32'h0});
    run_idle(30);
    chk("post_rst_rd", a_rdata, 32'hCAFE_F00D);

    rnd_en = 1;
    repeat (3000) cycle();
    rnd_en = 0;
    run_idle(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
